cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
//   Coprocessor-0 exception/interrupt controller at the M stage; the far end of the exception fields
//   (ExcCode, BD, pc) carried down the pipeline registers.
//   Decides whether to take an exception or interrupt and raises Req. Req flushes the D/E/M pipeline
//   registers and redirects fetch to 32'h0000_4180.
//   Holds SR, Cause, EPC and PRId, serves mfc0/mtc0, and supplies EPC for eret.
// PARAMETERS
//   PRID_VAL   32'h1234_5678   read-only value of PRId (reg 15)
//   EXC_ENTRY  32'h0000_4180   handler vector; exported for the NPC/pipeline-register flush logic
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high
//   en         in   1   mtc0 write enable (M stage)
//   CP0Addr    in   5   register index for mfc0/mtc0
//   CP0In      in   32  mtc0 write data
//   M_pc       in   32  pc of the M-stage instruction (victim pc)
//   M_BD       in   1   M-stage instruction sits in a delay slot
//   M_ExcCode  in   5   M-stage exception code; 0 = none
//   HWInt      in   6   external interrupt lines [7:2], level-sensitive
//   EXLClr     in   1   eret in M stage
//   CP0Out     out  32  mfc0 read data, combinational on CP0Addr
//   EPCOut     out  32  eret target
//   Req        out  1   take exception/interrupt this cycle (combinational)
// BEHAVIOUR
//   - Registers and fields:
//       SR[15:10] = IM, SR[1] = EXL, SR[0] = IE; all other SR bits read 0.
//       Cause[31] = BD, Cause[15:10] = IP, Cause[6:2] = ExcCode; all other Cause bits read 0.
//       EPC is 32 bits. PRId = PRID_VAL.
//   - Reset (async): SR, Cause and EPC clear to 0 immediately.
//     Req = 0 and EPCOut = 0 while reset is high.
//   - IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
//   - ExcReq = (M_ExcCode != 0) & ~SR.EXL.
//   - Req = IntReq | ExcReq. Zero latency: asserted in the same cycle the condition holds.
//   - Interrupt has priority over exception. On an interrupt the recorded code is 0; otherwise M_ExcCode.
//   - Posedge with Req=1:
//       SR.EXL <= 1; Cause.BD <= M_BD; Cause.ExcCode <= chosen code.
//       EPC <= M_BD ? {M_pc[31:2],2'b00} - 4 : {M_pc[31:2],2'b00}.
//       The mtc0 write and EXLClr are both ignored that cycle.
//   - Posedge with Req=0:
//       - EXLClr=1 clears SR.EXL.
//       - en=1 writes CP0In to SR (12) or EPC (14), field-masked.
//       - Writes to Cause, PRId or any other index are dropped.
//       - If EXLClr and an mtc0 to SR coincide, the write lands first and the EXL clear then wins.
//   - Cause.IP <= HWInt on every posedge (not reset), including Req cycles.
//   - CP0Out: 12 -> SR, 13 -> Cause, 14 -> EPC, 15 -> PRId, any other index -> 0.
//   - EPCOut bypass: when en & CP0Addr==14 & ~Req, EPCOut = {CP0In[31:2],2'b00}; otherwise EPCOut = EPC.
//     This lets an mtc0 EPC immediately before eret redirect correctly.
//   - Nesting: while EXL=1, Req stays 0 even with a pending interrupt or a nonzero M_ExcCode.
//     A pending interrupt fires in the cycle after EXLClr takes effect.
//   - A pipeline bubble arrives with ExcCode=0 and never raises Req. A bubble inserted by stall keeps
//     its pc/BD, so a later interrupt on it records the correct EPC.
// STRUCTURE
//   - Shared package cp0_pkg:
//       register indices: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
//       field bit positions for IM, EXL, IE, BD, IP and ExcCode.
//       ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYSCALL=8, EXC_RI=10, EXC_OV=12.
//       EXC_ENTRY value.
//   - One sub-module, cp0_req_gen (combinational): HWInt/IM/IE/EXL/M_ExcCode -> Req plus the chosen code.
//   - The top level holds the SR/Cause/EPC flops, the write mux and the read mux.
// TESTING
//   1. Reset mid-run:
//        after SR has been written to 32'h0000_FC01, assert reset for one cycle.
//        -> SR, Cause and EPC read 0 immediately; Req=0.
//   2. Exception, not in a delay slot:
//        M_ExcCode=10 (RI), M_pc=32'h0000_3010, M_BD=0, EXL=0.
//        -> Req=1 in the same cycle.
//        -> next cycle EPC=32'h0000_3010, Cause=32'h0000_0028, SR.EXL=1.
//   3. Exception in a delay slot:
//        M_ExcCode=12, M_pc=32'h0000_3024, M_BD=1.
//        -> EPC=32'h0000_3020, Cause[31]=1, Cause[6:2]=12.
//   4. Interrupt versus exception:
//        SR=32'h0000_0401 (IM[10], IE), HWInt=6'b000001, M_ExcCode=4 in the same cycle.
//        -> Req=1; recorded ExcCode=0; Cause.IP=6'b000001.
//        Then with EXL=1, raise M_ExcCode=5.
//        -> Req=0 and Cause is unchanged.
//   5. eret path:
//        mtc0 EPC <- 32'h0000_3103 with EXLClr=1 in the same cycle.
//        -> EPCOut=32'h0000_3100 in that cycle.
//        -> next cycle EXL=0, and a held HWInt line raises Req.
//   6. Masked write:
//        mtc0 Cause <- 32'hFFFF_FFFF, then mfc0 13; also mfc0 7.
//        -> Cause is unchanged and reg 7 reads 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, field positions and exception codes
package cp0_pkg;

  typedef enum logic [4:0] {
    CP0_SR    = 5'd12,
    CP0_CAUSE = 5'd13,
    CP0_EPC   = 5'd14,
    CP0_PRID  = 5'd15
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int SR_IM_HI     = 15;
  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [31:0] PRID_DEFAULT = 32'h1234_5678;
  localparam logic [31:0] EXC_ENTRY    = 32'h0000_4180;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_req_gen.sv
// rtl/cp0_req_gen.sv - combinational exception/interrupt request and code selection
module cp0_req_gen
  import cp0_pkg::*;
(
  input  logic [5:0] i_hw_int,
  input  logic [5:0] i_im,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_exc_code,
  output logic       o_req,
  output logic [4:0] o_code
);

  logic w_int_req;
  logic w_exc_req;

  assign w_int_req = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
  assign w_exc_req = (i_exc_code != EXC_INT) & ~i_exl;

  // Interrupts win over a concurrent synchronous exception.
  assign o_req  = w_int_req | w_exc_req;
  assign o_code = w_int_req ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 SR/Cause/EPC/PRId, exception request and eret target at the M stage
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0In,
  input  logic [31:0] M_pc,
  input  logic        M_BD,
  input  logic [4:0]  M_ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_req;
  logic [4:0]  w_code;
  logic [31:0] w_pc_al;
  logic [31:0] w_in_al;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_wr_sr;
  logic        w_wr_epc;

  cp0_req_gen u_req_gen (
    .i_hw_int   (HWInt),
    .i_im       (r_sr_im),
    .i_ie       (r_sr_ie),
    .i_exl      (r_sr_exl),
    .i_exc_code (M_ExcCode),
    .o_req      (w_req),
    .o_code     (w_code)
  );

  assign w_pc_al  = word_align(M_pc);
  assign w_in_al  = word_align(CP0In);
  assign w_wr_sr  = en & (CP0Addr == CP0_SR);
  assign w_wr_epc = en & (CP0Addr == CP0_EPC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr_im     <= '0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= '0;
      r_cause_exc <= '0;
      r_epc       <= '0;
    end else begin
      r_cause_ip <= HWInt;
      if (w_req) begin
        r_sr_exl    <= 1'b1;
        r_cause_bd  <= M_BD;
        r_cause_exc <= w_code;
        // A delay-slot victim restarts at its branch.
        r_epc       <= M_BD ? (w_pc_al - 32'd4) : w_pc_al;
      end else begin
        if (w_wr_sr) begin
          r_sr_im  <= CP0In[SR_IM_HI:SR_IM_LO];
          r_sr_exl <= CP0In[SR_EXL];
          r_sr_ie  <= CP0In[SR_IE];
        end else if (w_wr_epc) begin
          r_epc <= w_in_al;
        end
        if (EXLClr) begin
          r_sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sr                          = '0;
    w_sr[SR_IM_HI:SR_IM_LO]       = r_sr_im;
    w_sr[SR_EXL]                  = r_sr_exl;
    w_sr[SR_IE]                   = r_sr_ie;
    w_cause                       = '0;
    w_cause[CAUSE_BD]             = r_cause_bd;
    w_cause[CAUSE_IP_HI:CAUSE_IP_LO]   = r_cause_ip;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_cause_exc;
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Addr)
      CP0_SR:    CP0Out = w_sr;
      CP0_CAUSE: CP0Out = w_cause;
      CP0_EPC:   CP0Out = r_epc;
      CP0_PRID:  CP0Out = PRID_VAL;
      default:   CP0Out = '0;
    endcase
  end

  // Bypass lets an mtc0 EPC directly ahead of eret steer the redirect.
  assign Req    = w_req & ~reset;
  assign EPCOut = reset ? 32'd0 : ((w_wr_epc & ~w_req) ? w_in_al : r_epc);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - randomized and directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] M_pc;
  logic        M_BD;
  logic [4:0]  M_ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_sr, m_cause, m_epc;
  localparam logic [31:0] PRID = 32'h1234_5678;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Addr   (CP0Addr),
    .CP0In     (CP0In),
    .M_pc      (M_pc),
    .M_BD      (M_BD),
    .M_ExcCode (M_ExcCode),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .CP0Out    (CP0Out),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_int();
    return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((M_ExcCode != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epcout();
    if (en && CP0Addr == 5'd14 && !m_req()) return CP0In & 32'hFFFF_FFFC;
    return m_epc;
  endfunction

  task automatic model_edge();
    logic [31:0] ns, nc, ne;
    ns = m_sr;
    nc = m_cause;
    ne = m_epc;
    if (m_req()) begin
      ns[1]   = 1'b1;
      nc[31]  = M_BD;
      nc[6:2] = m_int() ? 5'd0 : M_ExcCode;
      ne      = (M_pc & 32'hFFFF_FFFC) - (M_BD ? 32'd4 : 32'd0);
    end else begin
      if (en && CP0Addr == 5'd12) ns = CP0In & 32'h0000_FC03;
      else if (en && CP0Addr == 5'd14) ne = CP0In & 32'hFFFF_FFFC;
      if (EXLClr) ns[1] = 1'b0;
    end
    nc[15:10] = HWInt;
    m_sr = ns;
    m_cause = nc;
    m_epc = ne;
  endtask

  task automatic cycle();
    @(negedge clk);
    check("req", {31'd0, Req}, {31'd0, m_req()});
    check("cp0out", CP0Out, m_read(CP0Addr));
    check("epcout", EPCOut, m_epcout());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    en = 1'b0; EXLClr = 1'b0; M_ExcCode = 5'd0; HWInt = 6'd0; M_BD = 1'b0;
    CP0Addr = 5'd12; CP0In = 32'd0; M_pc = 32'h0000_3000;
  endtask

  initial begin
    logic [4:0] addrs [6];
    idle();
    reset = 1'b1;
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(posedge clk); #1;
    for (int a = 12; a <= 14; a++) begin
      CP0Addr = 5'(a); #1;
      check("reset_reg", CP0Out, 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); model_edge(); #1;

    // reset mid-run
    CP0Addr = 5'd12; en = 1'b1; CP0In = 32'h0000_FC01;
    cycle();
    en = 1'b0; #1;
    check("sr_written", CP0Out, 32'h0000_FC01);
    reset = 1'b1; M_ExcCode = 5'd10; HWInt = 6'd1; #1;
    check("rst_req", {31'd0, Req}, 32'd0);
    check("rst_epcout", EPCOut, 32'd0);
    check("rst_sr", CP0Out, 32'd0);
    CP0Addr = 5'd13; #1;
    check("rst_cause", CP0Out, 32'd0);
    CP0Addr = 5'd14; #1;
    check("rst_epc", CP0Out, 32'd0);
    reset = 1'b0; idle();
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(posedge clk); model_edge(); #1;

    // exception, not in delay slot
    M_ExcCode = 5'd10; M_pc = 32'h0000_3010; M_BD = 1'b0; CP0Addr = 5'd13;
    #1 check("ri_req", {31'd0, Req}, 32'd1);
    cycle();
    M_ExcCode = 5'd0; CP0Addr = 5'd14; #1;
    check("ri_epc", CP0Out, 32'h0000_3010);
    CP0Addr = 5'd13; #1;
    check("ri_cause", CP0Out, 32'h0000_0028);
    CP0Addr = 5'd12; #1;
    check("ri_exl", {31'd0, CP0Out[1]}, 32'd1);

    // exception in delay slot
    EXLClr = 1'b1;
    cycle();
    EXLClr = 1'b0; M_ExcCode = 5'd12; M_pc = 32'h0000_3024; M_BD = 1'b1;
    cycle();
    M_ExcCode = 5'd0; M_BD = 1'b0; CP0Addr = 5'd14; #1;
    check("bd_epc", CP0Out, 32'h0000_3020);
    CP0Addr = 5'd13; #1;
    check("bd_bit", {31'd0, CP0Out[31]}, 32'd1);
    check("bd_code", {27'd0, CP0Out[6:2]}, 32'd12);

    // interrupt versus exception, then nesting
    en = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_0401; EXLClr = 1'b1;
    cycle();
    en = 1'b0; EXLClr = 1'b0; HWInt = 6'b000001; M_ExcCode = 5'd4; M_pc = 32'h0000_3040;
    CP0Addr = 5'd13; #1;
    check("int_req", {31'd0, Req}, 32'd1);
    cycle();
    check("int_code", {27'd0, CP0Out[6:2]}, 32'd0);
    check("int_ip", {26'd0, CP0Out[15:10]}, 32'd1);
    M_ExcCode = 5'd5; #1;
    check("nest_req", {31'd0, Req}, 32'd0);
    cycle();
    check("nest_cause", CP0Out, 32'h0000_0400);

    // eret path with held interrupt
    M_ExcCode = 5'd0; en = 1'b1; CP0Addr = 5'd14; CP0In = 32'h0000_3103; EXLClr = 1'b1; #1;
    check("eret_bypass", EPCOut, 32'h0000_3100);
    cycle();
    en = 1'b0; EXLClr = 1'b0; CP0Addr = 5'd12; M_pc = 32'h0000_3100; #1;
    check("eret_exl", {31'd0, CP0Out[1]}, 32'd0);
    check("eret_int", {31'd0, Req}, 32'd1);
    cycle();
    HWInt = 6'd0;
    cycle();

    // masked writes
    en = 1'b1; CP0Addr = 5'd13; CP0In = 32'hFFFF_FFFF;
    cycle();
    en = 1'b0; #1;
    check("cause_ro", CP0Out, m_cause);
    CP0Addr = 5'd7; #1;
    check("reg7", CP0Out, 32'd0);
    CP0Addr = 5'd15; #1;
    check("prid", CP0Out, 32'h1234_5678);

    // randomized traffic
    addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14;
    addrs[3] = 5'd15; addrs[4] = 5'd7;  addrs[5] = 5'd0;
    for (int i = 0; i < 500; i++) begin
      HWInt     = ($urandom % 4 == 0) ? 6'(1 << ($urandom % 6)) : 6'd0;
      M_ExcCode = ($urandom % 5 == 0) ? 5'($urandom % 32) : 5'd0;
      M_pc      = $urandom;
      M_BD      = 1'($urandom % 2);
      EXLClr    = ($urandom % 5 == 0);
      en        = ($urandom % 3 == 0);
      addrs[5]  = 5'($urandom % 32);
      CP0Addr   = addrs[$urandom % 6];
      CP0In     = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
